// File: rtl/rs_cdb_issue.sv
// Reservation station for one execution unit: allocates destination tags,
// captures operands broadcast on the common data bus and issues the oldest
// entry whose operands are all present.
module rs_cdb_issue #(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 8,
  parameter int NRSRC    = 2,
  parameter int NCDB     = 1,
  parameter int OPW      = 3,
  parameter int TAG_W    = 6,
  parameter int ID       = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             disp_valid,
  output logic                             disp_ready,
  input  logic [OPW-1:0]                   disp_op,
  input  logic [NRSRC-1:0]                 disp_rdy,
  input  logic [NRSRC-1:0][BITWIDTH-1:0]   disp_val,
  input  logic [NRSRC-1:0][TAG_W-1:0]      disp_tag,
  output logic [TAG_W-1:0]                 disp_dtag,
  input  logic [NCDB-1:0]                  cdb_valid,
  input  logic [NCDB-1:0][TAG_W-1:0]       cdb_tag,
  input  logic [NCDB-1:0][BITWIDTH-1:0]    cdb_data,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [OPW-1:0]                   issue_op,
  output logic [NRSRC-1:0][BITWIDTH-1:0]   issue_val,
  output logic [TAG_W-1:0]                 issue_dtag,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int SW  = $clog2(DEPTH);
  localparam int IDW = TAG_W - SW;
  localparam logic [IDW-1:0] ID_BITS  = IDW'(ID);
  localparam logic [SW-1:0]  AGE_MAX  = SW'(DEPTH - 1);
  localparam logic [SW:0]    CNT_FULL = (SW + 1)'(DEPTH);

  // Entry storage: control bits carry reset, payload does not.
  logic [DEPTH-1:0]                 ent_valid;
  logic [SW-1:0]                    ent_age  [DEPTH];
  logic [OPW-1:0]                   ent_op   [DEPTH];
  logic [NRSRC-1:0]                 ent_rdy  [DEPTH];
  logic [NRSRC-1:0][BITWIDTH-1:0]   ent_val  [DEPTH];
  logic [NRSRC-1:0][TAG_W-1:0]      ent_tag  [DEPTH];

  // Issue hold: the entry offered while the FU stalls stays selected.
  logic                             lock_valid;
  logic [SW-1:0]                    lock_slot;

  // Last presented issue payload, shown while the station is empty.
  logic [OPW-1:0]                   last_op;
  logic [NRSRC-1:0][BITWIDTH-1:0]   last_val;
  logic [TAG_W-1:0]                 last_dtag;

  logic [NRSRC-1:0]                 wake_hit  [DEPTH];
  logic [NRSRC-1:0][BITWIDTH-1:0]   wake_data [DEPTH];
  logic [NRSRC-1:0]                 byp_hit;
  logic [NRSRC-1:0][BITWIDTH-1:0]   byp_data;
  logic [DEPTH-1:0]                 ent_ready;
  logic                             oldest_found;
  logic [SW-1:0]                    oldest_slot;
  logic [SW-1:0]                    oldest_age;
  logic [SW-1:0]                    alloc_slot;
  logic [SW-1:0]                    sel_slot;
  logic [SW-1:0]                    issued_age;
  logic                             issue_fire;
  logic                             disp_fire;
  logic [SW-1:0]                    age_next [DEPTH];

  // CDB tag match for stored operands and for the operands being dispatched;
  // scanning ports downward lets the lowest matching port win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    byp_hit  = '0;
    byp_data = '0;
    for (int j = 0; j < DEPTH; j++) begin
      wake_hit[j]  = '0;
      wake_data[j] = '0;
    end
    for (int i = 0; i < NRSRC; i++) begin
      for (int k = NCDB - 1; k >= 0; k--) begin
        if (cdb_valid[k] && cdb_tag[k] == disp_tag[i]) begin
          byp_hit[i]  = !disp_rdy[i];
          byp_data[i] = cdb_data[k];
        end
      end
      for (int j = 0; j < DEPTH; j++) begin
        for (int k = NCDB - 1; k >= 0; k--) begin
          if (cdb_valid[k] && cdb_tag[k] == ent_tag[j][i]) begin
            wake_hit[j][i]  = ent_valid[j] && !ent_rdy[j][i];
            wake_data[j][i] = cdb_data[k];
          end
        end
      end
    end
  end

  // Oldest-ready pick and lowest-free-slot allocation from registered state.
  always_comb begin
    oldest_found = 1'b0;
    oldest_slot  = '0;
    oldest_age   = '0;
    alloc_slot   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      ent_ready[j] = ent_valid[j] && (&ent_rdy[j]);
      if (ent_ready[j] && (!oldest_found || ent_age[j] > oldest_age)) begin
        oldest_found = 1'b1;
        oldest_slot  = SW'(j);
        oldest_age   = ent_age[j];
      end
    end
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (!ent_valid[j]) alloc_slot = SW'(j);
    end
  end

  assign sel_slot    = lock_valid ? lock_slot : oldest_slot;
  assign issue_valid = lock_valid || oldest_found;
  assign issued_age  = ent_age[sel_slot];
  assign disp_ready  = (count != CNT_FULL);
  assign disp_dtag   = {ID_BITS, alloc_slot};
  assign issue_fire  = issue_valid && issue_ready && !flush;
  assign disp_fire   = disp_valid && disp_ready && !flush;
  assign issue_op    = issue_valid ? ent_op[sel_slot]  : last_op;
  assign issue_val   = issue_valid ? ent_val[sel_slot] : last_val;
  assign issue_dtag  = issue_valid ? {ID_BITS, sel_slot} : last_dtag;

  // Age update for surviving entries: close the gap left by the issued entry,
  // then make room for the newcomer at age 0.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      age_next[j] = ent_age[j];
      if (issue_fire && ent_age[j] > issued_age) age_next[j] = age_next[j] - 1'b1;
      if (disp_fire && age_next[j] < AGE_MAX)    age_next[j] = age_next[j] + 1'b1;
    end
  end

  // Control state: valid bits, ages, occupancy, issue hold and last payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      ent_valid  <= '0;
      for (int j = 0; j < DEPTH; j++) ent_age[j] <= '0;
      count      <= '0;
      lock_valid <= 1'b0;
      lock_slot  <= '0;
      last_op    <= '0;
      last_val   <= '0;
      last_dtag  <= '0;
    end else begin
      if (issue_valid) begin
        last_op   <= issue_op;
        last_val  <= issue_val;
        last_dtag <= issue_dtag;
      end
      if (flush) begin
        ent_valid  <= '0;
        for (int j = 0; j < DEPTH; j++) ent_age[j] <= '0;
        count      <= '0;
        lock_valid <= 1'b0;
      end else begin
        lock_valid <= issue_valid && !issue_ready;
        lock_slot  <= sel_slot;
        count      <= count + (SW + 1)'(disp_fire) - (SW + 1)'(issue_fire);
        for (int j = 0; j < DEPTH; j++) begin
          if (ent_valid[j]) ent_age[j] <= age_next[j];
        end
        if (issue_fire) ent_valid[sel_slot] <= 1'b0;
        if (disp_fire) begin
          ent_valid[alloc_slot] <= 1'b1;
          ent_age[alloc_slot]   <= '0;
        end
      end
    end
  end

  // Operand payload: dispatch writes (with same-cycle CDB bypass) and wakeups.
  always_ff @(posedge clk) begin
    // NOTE: payload is left unreset on purpose; it is only observed through valid bits that are reset.
    for (int j = 0; j < DEPTH; j++) begin
      for (int i = 0; i < NRSRC; i++) begin
        if (wake_hit[j][i]) begin
          ent_rdy[j][i] <= 1'b1;
          ent_val[j][i] <= wake_data[j][i];
        end
      end
    end
    if (disp_fire) begin
      ent_op[alloc_slot]  <= disp_op;
      ent_tag[alloc_slot] <= disp_tag;
      for (int i = 0; i < NRSRC; i++) begin
        ent_rdy[alloc_slot][i] <= disp_rdy[i] || byp_hit[i];
        ent_val[alloc_slot][i] <= byp_hit[i] ? byp_data[i] : disp_val[i];
      end
    end
  end

endmodule
